fun: RTL and testbench



---
 rtl/fun.sv | 127 ++++++++++++
 tb/tb_fun.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fun.sv
// Iterative unit computing a * floor(cbrt(b)) for 8-bit operands, 11-bit result.
// Latency 42 cycles of busy per operation; start is ignored while busy (no queueing).
module fun (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic        start,
    output logic [10:0] result,
    output logic        busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] Y_SHIFT   = 3'd1;
    localparam logic [2:0] MUL_YY    = 3'd2;
    localparam logic [2:0] TERM      = 3'd3;
    localparam logic [2:0] CMP       = 3'd4;
    localparam logic [2:0] FINAL_MUL = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]  state;
    logic [7:0]  a_r;
    logic [7:0]  x;
    logic [3:0]  y;
    logic [1:0]  iter;
    logic [15:0] t;
    logic [10:0] acc;
    logic [10:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;

    logic [3:0]  y_dbl;
    logic [3:0]  y_fin;
    logic        ge;
    logic [15:0] p_ext;
    logic [15:0] term_base;
    logic [15:0] term_val;

    always_comb begin
        y_dbl     = {y[2:0], 1'b0};
        ge        = ({8'd0, x} >= t);
        y_fin     = y + {3'd0, ge};
        p_ext     = {5'd0, acc};
        // 3*p + 1 via shift/add, kept 16 bits wide so the shift below never truncates
        term_base = (p_ext << 1) + p_ext + 16'd1;
        case (iter)
            2'd0:    term_val = term_base << 6;
            2'd1:    term_val = term_base << 3;
            default: term_val = term_base;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            a_r    <= '0;
            x      <= '0;
            y      <= '0;
            iter   <= '0;
            t      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a_i;
                        x     <= b_i;
                        y     <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= Y_SHIFT;
                    end
                end
                Y_SHIFT: begin
                    y      <= y_dbl;
                    mcand  <= {7'd0, y_dbl};
                    mplier <= {4'd0, y_dbl + 4'd1};
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL_YY;
                end
                MUL_YY, FINAL_MUL: begin
                    // The true product always fits in 11 bits, so dropping high mcand bits is harmless
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= (state == MUL_YY) ? TERM : DONE;
                end
                TERM: begin
                    t     <= term_val;
                    state <= CMP;
                end
                CMP: begin
                    if (ge) begin
                        x <= x - t[7:0];
                        y <= y_fin;
                    end
                    if (iter == 2'd2) begin
                        mcand  <= {3'd0, a_r};
                        mplier <= {4'd0, y_fin};
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= FINAL_MUL;
                    end else begin
                        iter  <= iter + 2'd1;
                        state <= Y_SHIFT;
                    end
                end
                DONE: begin
                    result <= acc;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fun.sv
// Directed and sampled checks of fun: reset, arithmetic, boundaries, busy-time
// operand isolation, mid-operation abort and back-to-back starts.
module tb_fun;

    logic        clk;
    logic        rst;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        start;
    logic [10:0] result;
    logic        busy;

    int checks;
    int failures;

    fun dut (
        .clk    (clk),
        .rst    (rst),
        .a_i    (a_i),
        .b_i    (b_i),
        .start  (start),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int a, input int b);
        int y;
        y = 0;
        while ((y + 1) * (y + 1) * (y + 1) <= b)
            y++;
        return a * y;
    endfunction

    // Called at a negedge; returns at the negedge right after busy falls.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int res, output int lat, output logic busy_first);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        busy_first = busy;
        lat        = 0;
        while (busy && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        res = int'(result);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a_i   = 8'd0;
        b_i   = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (result !== 11'd0) begin
            failures++;
            $display("FAIL reset_result: got %0d expected 0", result);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int res, lat;
        logic bf;
        run_op(8'd5, 8'd27, res, lat, bf);
        checks++;
        if (bf !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_rise: got %b expected 1", bf);
        end
        checks++;
        if (lat != 42) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 42", lat);
        end
        checks++;
        if (res != 15) begin
            failures++;
            $display("FAIL basic_result: got %0d expected 15", res);
        end
        a_i = 8'd77;
        b_i = 8'd200;
        repeat (5) @(negedge clk);
        checks++;
        if (result !== 11'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got result=%0d busy=%b expected 15/0", result, busy);
        end
    endtask

    task automatic test_back_to_back();
        int res, lat;
        logic bf;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(8'd3, 8'd64, res, lat, bf);
        checks++;
        if (res != 12 || lat != 42) begin
            failures++;
            $display("FAIL b2b_first: got %0d lat %0d expected 12 lat 42", res, lat);
        end
        run_op(8'd9, 8'd125, res, lat, bf);
        checks++;
        if (res != 45 || lat != 42 || bf !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got %0d lat %0d busy %b expected 45 lat 42 busy 1", res, lat, bf);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [7];
        logic [7:0] tb [7];
        int         te [7];
        int res, lat;
        logic bf;
        ta = '{8'd255, 8'd255, 8'd7, 8'd0,   8'd200, 8'd1,  8'd1};
        tb = '{8'd255, 8'd215, 8'd0, 8'd200, 8'd1,   8'd63, 8'd216};
        te = '{1530,   1275,   0,    0,      200,    3,     6};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], res, lat, bf);
            checks++;
            if (res != te[i] || lat != 42) begin
                failures++;
                $display("FAIL boundary_%0d a=%0d b=%0d: got %0d lat %0d expected %0d lat 42",
                         i, ta[i], tb[i], res, lat, te[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        a_i   = 8'd11;
        b_i   = 8'd100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (busy && lat < 200) begin
            lat++;
            if (lat == 10) begin
                a_i   = 8'd250;
                b_i   = 8'd250;
                start = 1'b1;
            end else if (lat == 12) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (result !== 11'd44 || lat != 42) begin
            failures++;
            $display("FAIL ignore_busy: got %0d lat %0d expected 44 lat 42", result, lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy_no_queue: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_abort();
        int res, lat;
        logic bf;
        run_op(8'd4, 8'd8, res, lat, bf);
        a_i   = 8'd100;
        b_i   = 8'd255;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== 11'd0) begin
            failures++;
            $display("FAIL abort_reset: got busy %b result %0d expected 0/0", busy, result);
        end
        rst = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== 11'd0) begin
            failures++;
            $display("FAIL abort_no_result: got busy %b result %0d expected 0/0", busy, result);
        end
        run_op(8'd13, 8'd30, res, lat, bf);
        checks++;
        if (res != 39 || lat != 42) begin
            failures++;
            $display("FAIL abort_recover: got %0d lat %0d expected 39 lat 42", res, lat);
        end
    endtask

    task automatic test_sweep();
        int res, lat, exp_r;
        logic bf;
        logic [7:0] a, b;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i < 256) ? 8'(i) : 8'($urandom_range(0, 255));
            exp_r = model(int'(a), int'(b));
            run_op(a, b, res, lat, bf);
            checks++;
            if (res != exp_r || lat != 42) begin
                failures++;
                $display("FAIL sweep a=%0d b=%0d: got %0d lat %0d expected %0d lat 42",
                         a, b, res, lat, exp_r);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundaries();
        test_ignore_busy();
        test_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
